sync_gen_ctrl: RTL and testbench

Sequencer for the design's sync generator. It turns the control word written by software through the `sync_gen_sync` software register into sync pulses on `sync_out`. Three trigger modes are supported: one-shot, periodic, and armed-external. The block sits in the `user_clk` domain directly downstream of the register's `user_data_out`, and drives the sync input of the DSP chain.

---
 rtl/sync_gen_pkg.sv | 16 +
 rtl/sync_edge_detect.sv | 27 ++
 rtl/sync_gen_ctrl.sv | 126 ++++++++++++
 tb/tb_sync_gen_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/sync_gen_pkg.sv
// rtl/sync_gen_pkg.sv - shared types and control-word bit positions for the sync generator
package sync_gen_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_PULSE = 2'd2,
      ST_WAIT  = 2'd3
   } sync_state_t;

   localparam int CTRL_ARM      = 0;
   localparam int CTRL_PERIODIC = 1;
   localparam int CTRL_EXT      = 2;
   localparam int CTRL_ABORT    = 3;

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - two-flop synchronizer followed by a rising-edge detector
module sync_edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic rise
);

   logic meta;
   logic sync;
   logic sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta   <= 1'b0;
         sync   <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta   <= async_in;
         sync   <= meta;
         sync_q <= sync;
      end
   end

   assign rise = sync & ~sync_q;

endmodule

// File: rtl/sync_gen_ctrl.sv
// rtl/sync_gen_ctrl.sv - one-shot / periodic / external-trigger sync pulse sequencer
// Optional pulse counter output sync_count is built when SYNC_GEN_COUNT_EN is defined.
module sync_gen_ctrl
   import sync_gen_pkg::*;
#(
   parameter int PERIOD_W  = 24,
   parameter int PULSE_LEN = 4
`ifdef SYNC_GEN_COUNT_EN
   , parameter int CNT_W   = 16
`endif
) (
   input  logic                user_clk,
   input  logic                user_rst,
   input  logic [31:0]         ctrl_word,
   input  logic [PERIOD_W-1:0] period,
   input  logic                ext_sync,
   output logic                sync_out,
   output logic                armed,
   output logic                busy
`ifdef SYNC_GEN_COUNT_EN
   , output logic [CNT_W-1:0]  sync_count
`endif
);

   localparam int              PCNT_W     = $clog2(PULSE_LEN + 1);
   localparam logic [PERIOD_W:0] MIN_PERIOD = (PERIOD_W + 1)'(PULSE_LEN + 1);

   sync_state_t         state;
   sync_state_t         state_nxt;
   logic                arm_q;
   logic                arm_edge;
   logic                abort;
   logic                ext_edge;
   logic                per_lat;
   logic [PERIOD_W:0]   eff_period;
   logic [PERIOD_W:0]   eff_lat;
   logic [PERIOD_W:0]   wcnt;
   logic [PCNT_W-1:0]   pcnt;
   logic                enter_pulse;
   logic                unused_ctrl;

   assign unused_ctrl = ^ctrl_word[31:4];
   assign abort       = ctrl_word[CTRL_ABORT];
   assign arm_edge    = ctrl_word[CTRL_ARM] & ~arm_q;
   assign enter_pulse = (state_nxt == ST_PULSE) && (state != ST_PULSE);

   // Clamp keeps room for the pulse plus at least one low cycle.
   assign eff_period = ({1'b0, period} < MIN_PERIOD) ? MIN_PERIOD : {1'b0, period};

   sync_edge_detect u_ext_edge (
      .clk      (user_clk),
      .rst      (user_rst),
      .async_in (ext_sync),
      .rise     (ext_edge)
   );

   always_ff @(posedge user_clk or posedge user_rst) begin
      if (user_rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (abort) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:  if (arm_edge) state_nxt = ctrl_word[CTRL_EXT] ? ST_ARMED : ST_PULSE;
            ST_ARMED: if (ext_edge) state_nxt = ST_PULSE;
            ST_PULSE: if (pcnt == '0) state_nxt = per_lat ? ST_WAIT : ST_IDLE;
            ST_WAIT:  if (wcnt == '0) state_nxt = ST_PULSE;
            default:  state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge user_clk or posedge user_rst) begin
      if (user_rst) begin
         arm_q    <= 1'b1;
         sync_out <= 1'b0;
         armed    <= 1'b0;
         busy     <= 1'b0;
         per_lat  <= 1'b0;
         eff_lat  <= '0;
         pcnt     <= '0;
         wcnt     <= '0;
      end else begin
         arm_q    <= ctrl_word[CTRL_ARM];
         sync_out <= (state_nxt == ST_PULSE);
         armed    <= (state_nxt == ST_ARMED);
         busy     <= (state_nxt != ST_IDLE);

         if (state == ST_IDLE && state_nxt != ST_IDLE) begin
            per_lat <= ctrl_word[CTRL_PERIODIC];
            eff_lat <= eff_period;
         end

         if (enter_pulse) begin
            pcnt <= PCNT_W'(PULSE_LEN - 1);
         end else if (state == ST_PULSE && pcnt != '0) begin
            pcnt <= pcnt - PCNT_W'(1);
         end

         // WAIT covers the rest of the period after the pulse cycles.
         if (state_nxt == ST_WAIT && state != ST_WAIT) begin
            wcnt <= eff_lat - MIN_PERIOD;
         end else if (state == ST_WAIT && wcnt != '0) begin
            wcnt <= wcnt - (PERIOD_W + 1)'(1);
         end
      end
   end

`ifdef SYNC_GEN_COUNT_EN
   always_ff @(posedge user_clk or posedge user_rst) begin
      if (user_rst) begin
         sync_count <= '0;
      end else if (enter_pulse) begin
         sync_count <= sync_count + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_sync_gen_ctrl.sv
// tb/tb_sync_gen_ctrl.sv - scoreboard bench for sync_gen_ctrl
module tb_sync_gen_ctrl;

   localparam int PERIOD_W  = 24;
   localparam int PULSE_LEN = 4;
`ifdef SYNC_GEN_COUNT_EN
   localparam int CNT_W     = 4;
`endif

   logic                user_clk  = 1'b0;
   logic                user_rst  = 1'b1;
   logic [31:0]         ctrl_word = '0;
   logic [PERIOD_W-1:0] period    = '0;
   logic                ext_sync  = 1'b0;
   logic                sync_out;
   logic                armed;
   logic                busy;
`ifdef SYNC_GEN_COUNT_EN
   logic [CNT_W-1:0]    sync_count;
`endif

   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc      = 0;
   int   n_pushed = 0;
   int   hi_cnt   = 0;
   logic so_q     = 1'b0;
   int   exp_q[$];

   sync_gen_ctrl #(
      .PERIOD_W  (PERIOD_W),
      .PULSE_LEN (PULSE_LEN)
`ifdef SYNC_GEN_COUNT_EN
      , .CNT_W   (CNT_W)
`endif
   ) dut (
      .user_clk  (user_clk),
      .user_rst  (user_rst),
      .ctrl_word (ctrl_word),
      .period    (period),
      .ext_sync  (ext_sync),
      .sync_out  (sync_out),
      .armed     (armed),
      .busy      (busy)
`ifdef SYNC_GEN_COUNT_EN
      , .sync_count (sync_count)
`endif
   );

   always #5 user_clk = ~user_clk;
   always @(posedge user_clk) cyc <= cyc + 1;

   task automatic check(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge user_clk);
         #1;
      end
   endtask

   task automatic expect_rise(input int c);
      exp_q.push_back(c);
      n_pushed++;
   endtask

   task automatic check_count(input string tag);
`ifdef SYNC_GEN_COUNT_EN
      check(tag, sync_count, n_pushed % (1 << CNT_W));
`else
      check(tag, busy, 1'b0);
`endif
   endtask

   // Rising edges of sync_out are matched against the expected-edge queue.
   always @(negedge user_clk) begin
      if (user_rst) begin
         hi_cnt = 0;
      end else begin
         if (sync_out && !so_q) begin
            if (exp_q.size() == 0) check("unexpected_rise", cyc, -1);
            else check("rise_cycle", cyc, exp_q.pop_front());
         end
         if (sync_out) begin
            hi_cnt++;
         end else if (so_q) begin
            check("pulse_len", hi_cnt, PULSE_LEN);
            hi_cnt = 0;
         end
      end
      so_q = sync_out;
   end

   task automatic run_periodic(input int per, input int npulses, input bit rearm);
      int p;
      int c;
      int e;
      p = (per > PULSE_LEN) ? per : PULSE_LEN + 1;
      period = PERIOD_W'(per);
      ctrl_word = 32'h0;
      tick();
      ctrl_word = 32'h3;
      c = cyc;
      for (int i = 0; i < npulses; i++) expect_rise(c + 1 + i * p);
      e = c + 1 + (npulses - 1) * p;
      if (rearm) begin
         tick(PULSE_LEN + 1);
         check("rearm_in_wait", busy, 1'b1);
         ctrl_word = 32'h2;
         tick();
         ctrl_word = 32'h3;
         period = PERIOD_W'(3);
      end
      while (cyc < e + PULSE_LEN) tick();
      ctrl_word = 32'hB;
      tick();
      check("abort_sync_out", sync_out, 1'b0);
      check("abort_busy", busy, 1'b0);
      check("abort_armed", armed, 1'b0);
      ctrl_word = 32'h0;
      tick(2 * p);
      check("periodic_drain", exp_q.size(), 0);
   endtask

   initial begin
      ctrl_word = 32'h1;
      tick(3);
      check("rst_sync_out", sync_out, 1'b0);
      check("rst_armed", armed, 1'b0);
      check("rst_busy", busy, 1'b0);
      check_count("rst_count");
      user_rst = 1'b0;
      tick(10);
      check("held_arm_busy", busy, 1'b0);
      ctrl_word = 32'h0;
      tick(2);

      ctrl_word = 32'h1;
      expect_rise(cyc + 1);
      for (int i = 0; i < 6; i++) begin
         tick();
         check("oneshot_busy", busy, (i < PULSE_LEN) ? 1 : 0);
         check("oneshot_sync_out", sync_out, (i < PULSE_LEN) ? 1 : 0);
      end
      check_count("oneshot_count");
      ctrl_word = 32'h0;
      tick(2);
      check("oneshot_drain", exp_q.size(), 0);

      run_periodic(10, 5, 1'b0);
      run_periodic(2, 3, 1'b0);
      run_periodic(0, 3, 1'b0);
      run_periodic(10, 3, 1'b1);

      ctrl_word = 32'h0;
      tick();
      ctrl_word = 32'h9;
      tick();
      check("abort_arm_busy", busy, 1'b0);
      tick(3);
      ctrl_word = 32'h1;
      tick(5);
      check("abort_release_busy", busy, 1'b0);
      check("abort_release_sync", sync_out, 1'b0);
      ctrl_word = 32'h0;
      tick(2);

      ctrl_word = 32'h5;
      tick();
      check("ext_armed", armed, 1'b1);
      check("ext_busy", busy, 1'b1);
      tick(100);
      check("ext_still_armed", armed, 1'b1);
      ext_sync = 1'b1;
      expect_rise(cyc + 3);
      tick(2);
      ext_sync = 1'b0;
      tick();
      check("ext_sync_out", sync_out, 1'b1);
      check("ext_armed_clear", armed, 1'b0);
      tick(6);
      check("ext_busy_done", busy, 1'b0);
      ctrl_word = 32'h0;
      tick(2);
      check("ext_drain", exp_q.size(), 0);
      check_count("count_before_wrap");

`ifdef SYNC_GEN_COUNT_EN
      run_periodic(0, 20, 1'b0);
      check_count("count_wrap");
`endif

      ctrl_word = 32'h1;
      expect_rise(cyc + 1);
      tick(2);
      #2 user_rst = 1'b1;
      #1;
      check("async_rst_sync_out", sync_out, 1'b0);
      check("async_rst_busy", busy, 1'b0);
      n_pushed = 0;
      check_count("async_rst_count");
      ctrl_word = 32'h0;
      tick(2);
      user_rst = 1'b0;
      tick(3);
      check("final_drain", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
